// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the wait-state data memory.
//   - RV32I load/store funct3 encodings
//   - controller state encoding
//   - helpers: request legality, alignment, byte enables,
//     store lane replication and load extension
// The lane helpers work on a 32-bit word (RV32I).
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Unsigned variants exist only for loads.
  function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !write;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

  // funct3[1:0] encodes the access size for every legal funct3.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the low store bytes onto every lane; byte_en picks the live one.
  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   store_lanes = {4{wdata[7:0]}};
      2'b01:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_BU:   load_ext = {24'h0, b};
      F3_HU:   load_ext = {16'h0, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH_WORDS x XLEN byte-lane RAM.
//   clk   - write clock
//   we    - per-byte write enable (bit i -> bits [8i+7:8i])
//   addr  - word index, shared by read and write
//   wdata - write data, lane aligned
//   rdata - asynchronous read of mem[addr]
module dmem_bank #(
  parameter  int XLEN        = 32,
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS),
  localparam int NB          = XLEN / 8
) (
  input  logic            clk,
  input  logic [NB-1:0]   we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset; contents survive reset and power up undefined, which lets it map onto RAM macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: data memory for the pipeline memory stage with
// LATENCY wait states, byte/half/word access and error reporting.
//   clk, reset         - clock, synchronous active-high reset
//   req_valid          - memory-stage instruction is a load/store
//   req_write          - 1 store, 0 load
//   req_funct3         - RV32I load/store funct3
//   req_addr/req_wdata - byte address / store data (low bytes for sb/sh)
//   stall              - hold pipeline up to and including memory
//   rsp_valid          - one-cycle completion pulse
//   rsp_rdata          - extended load data, 0 for stores and errors
//   access_err         - with rsp_valid: misaligned or illegal funct3
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            access_err
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            commit;
  logic            req_err;

  logic            cap_write;
  logic [2:0]      cap_funct3;
  logic [XLEN-1:0] cap_addr, cap_wdata;

  logic            acc_write;
  logic [2:0]      acc_funct3;
  logic [XLEN-1:0] acc_addr, acc_wdata;

  logic [XLEN/8-1:0] bank_we;
  logic [XLEN-1:0]   bank_rdata;
  logic              unused_addr_bits;

  assign req_err = !funct3_legal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);

  // With LATENCY=0 the commit happens on the accept edge, before the
  // capture registers load, so IDLE commits from the live request.
  assign acc_write  = (state == IDLE) ? req_write  : cap_write;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
  assign acc_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;

  // Address bits above the RAM index are ignored, so addresses wrap.
  assign unused_addr_bits = ^acc_addr[XLEN-1:AW+2];

  assign rsp_valid = (state == RESP);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          stall = !reset;
          if (req_err) begin
            state_nx = RESP;
          end else if (LATENCY == 0) begin
            commit   = 1'b1;
            state_nx = RESP;
          end else begin
            cnt_nx   = LAT;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_nx = cnt - 4'd1;
        // Commit on the edge where the count reaches zero: LATENCY WAIT cycles.
        if (cnt == 4'd1) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A reset landing on the commit edge must abort the pending store.
  assign bank_we = (commit && acc_write && !reset) ? byte_en(acc_funct3, acc_addr[1:0]) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_rdata  <= '0;
      access_err <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      access_err <= (state == IDLE) && req_valid && req_err;
      if (commit) begin
        rsp_rdata <= acc_write ? '0 : load_ext(acc_funct3, acc_addr[1:0], bank_rdata);
      end else if (state == RESP) begin
        rsp_rdata <= '0;
      end
    end
  end

  // Request capture needs no reset: WAIT is only ever entered through it.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      cap_write  <= req_write;
      cap_funct3 <= req_funct3;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
    end
  end

  dmem_bank #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (store_lanes(acc_funct3, acc_wdata)),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Scoreboard bench for dmem_wait_ctrl: instance 0 built with LATENCY=2,
// instance 1 with LATENCY=0. Drivers push expected responses into a
// per-instance queue; monitors pop and compare on every rsp_valid.
module tb_dmem_wait_ctrl;

  localparam bit [2:0] B = 3'd0, H = 3'd1, W = 3'd2, BU = 3'd4, HU = 3'd5;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] run;   // stall cycles immediately preceding rsp_valid
  } exp_t;

  logic        clk;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        stall      [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        access_err [2];

  exp_t        exp_q [2][$];
  logic [7:0]  mm [2][4096];   // reference byte memory, one per instance
  int          n_checks = 0;
  int          n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_wait_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .stall(stall[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .access_err(access_err[0])
  );

  dmem_wait_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .stall(stall[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .access_err(access_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference: size/sign from funct3, natural alignment, little-endian bytes.
  function automatic exp_t model(input int k, input bit wr, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] wd);
    exp_t        e;
    int          size;
    bit          uns;
    bit          ok;
    int          base;
    logic [31:0] v;
    ok = 1'b1; uns = 1'b0; size = 4;
    case (f3)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      3'd4:    begin size = 1; uns = 1'b1; ok = !wr; end
      3'd5:    begin size = 2; uns = 1'b1; ok = !wr; end
      default: ok = 1'b0;
    endcase
    if (ok && (a % size) != 0) ok = 1'b0;
    e.err   = !ok;
    e.run   = ok ? 32'(lat(k) + 1) : 32'd1;
    e.rdata = '0;
    if (ok) begin
      base = int'(a[11:0]);
      if (wr) begin
        for (int i = 0; i < size; i++) mm[k][base+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(mm[k][base+i]) << (8*i));
        if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Drives one request and waits (bounded) for its response. Directed calls
  // supply the required result as constants; the model still tracks memory.
  task automatic issue(input int k, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit dir = 1'b0,
                       input bit [31:0] c_rdata = 32'd0, input bit c_err = 1'b0);
    exp_t e;
    bit   seen;
    e = model(k, wr, f3, a, wd);
    if (dir) begin
      e.rdata = c_rdata;
      e.err   = c_err;
      e.run   = c_err ? 32'd1 : 32'(lat(k) + 1);
    end
    exp_q[k].push_back(e);
    req_valid[k]  = 1'b1;
    req_write[k]  = wr;
    req_funct3[k] = f3;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (rsp_valid[k] === 1'b1);
    end
    check($sformatf("i%0d_rsp_seen", k), 32'(seen), 32'd1);
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check($sformatf("i%0d_%s_rsp_valid", k, tag), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("i%0d_%s_rsp_rdata", k, tag), rsp_rdata[k], 32'd0);
    check($sformatf("i%0d_%s_access_err", k, tag), 32'(access_err[k]), 32'd0);
    check($sformatf("i%0d_%s_stall", k, tag), 32'(stall[k]), 32'd0);
  endtask

  task automatic init_window(input int k);
    for (int i = 0; i < 16; i++) issue(k, 1'b1, W, 32'h100 + 32'(4*i), $urandom);
  endtask

  task automatic rand_phase(input int k, input int n_ops);
    for (int i = 0; i < n_ops; i++) begin
      bit        wr;
      bit [2:0]  f3;
      bit [31:0] a;
      int        off;
      wr  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) off = off & ~3;
        else if (f3[1:0] == 2'b01) off = off & ~1;
      end
      a = (32'($urandom_range(0, 15)) << 12) | (32'h100 + 32'(off));
      if ($urandom_range(0, 3) == 0) begin
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      issue(k, wr, f3, a, $urandom);
    end
    req_valid[k] = 1'b0;
  endtask

  // Monitors sample 2 time units after the falling edge, after any driver update.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      int   run;
      exp_t e;
      run = 0;
      forever begin
        @(negedge clk);
        #2;
        if (reset[g] !== 1'b0) begin
          run = 0;
        end else if (rsp_valid[g] === 1'b1) begin
          check($sformatf("i%0d_rsp_pending", g), 32'(exp_q[g].size() != 0), 32'd1);
          if (exp_q[g].size() != 0) begin
            e = exp_q[g].pop_front();
            check($sformatf("i%0d_rdata", g), rsp_rdata[g], e.rdata);
            check($sformatf("i%0d_access_err", g), 32'(access_err[g]), 32'(e.err));
            check($sformatf("i%0d_stall_cycles", g), 32'(run), e.run);
            check($sformatf("i%0d_stall_in_resp", g), 32'(stall[g]), 32'd0);
          end
          run = 0;
        end else begin
          if (access_err[g] !== 1'b0)
            check($sformatf("i%0d_err_without_rsp", g), 32'(access_err[g]), 32'd0);
          run = (stall[g] === 1'b1) ? run + 1 : 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within 400000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_funct3[k] = 3'd0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b1; req_write[k] = 1'b1; req_funct3[k] = W;
      req_addr[k] = 32'h104; req_wdata[k] = 32'hFFFF_FFFF;
    end
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("i%0d_stall_under_reset", k), 32'(stall[k]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin req_valid[k] = 1'b0; reset[k] = 1'b0; end
    #1;
    for (int k = 0; k < 2; k++) check_idle_outputs(k, "after_reset");
    @(negedge clk);

    // ---- LATENCY=2: word, byte, halfword and error paths ----
    issue(0, 1, W,  32'h100, 32'hDEAD_BEEF, 1, 32'h0,         0);
    issue(0, 0, W,  32'h100, 32'h0,         1, 32'hDEAD_BEEF, 0);
    issue(0, 1, B,  32'h101, 32'h0000_0080, 1, 32'h0,         0);
    issue(0, 0, B,  32'h101, 32'h0,         1, 32'hFFFF_FF80, 0);
    issue(0, 0, BU, 32'h101, 32'h0,         1, 32'h0000_0080, 0);
    issue(0, 0, W,  32'h100, 32'h0,         1, 32'hDEAD_80EF, 0);
    issue(0, 1, H,  32'h102, 32'h0000_8001, 1, 32'h0,         0);
    issue(0, 0, H,  32'h102, 32'h0,         1, 32'hFFFF_8001, 0);
    issue(0, 0, HU, 32'h102, 32'h0,         1, 32'h0000_8001, 0);
    issue(0, 0, W,  32'h102, 32'h0,         1, 32'h0,         1);
    issue(0, 1, W,  32'h103, 32'h1111_1111, 1, 32'h0,         1);
    issue(0, 1, 3'd3, 32'h100, 32'h2222_2222, 1, 32'h0,       1);
    issue(0, 1, 3'd6, 32'h100, 32'h3333_3333, 1, 32'h0,       1);
    issue(0, 1, BU, 32'h100, 32'h4444_4444, 1, 32'h0,         1);
    issue(0, 0, 3'd3, 32'h100, 32'h0,       1, 32'h0,         1);
    issue(0, 0, 3'd7, 32'h100, 32'h0,       1, 32'h0,         1);
    issue(0, 0, H,  32'h101, 32'h0,         1, 32'h0,         1);
    issue(0, 0, W,  32'h100, 32'h0,         1, 32'h8001_80EF, 0);

    // Reset lands on the commit edge of a pending store: it must be dropped.
    issue(0, 1, W, 32'h200, 32'h1111_1111, 1, 32'h0, 0);
    req_write[0] = 1'b1; req_funct3[0] = W; req_addr[0] = 32'h200; req_wdata[0] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    reset[0] = 1'b1; req_valid[0] = 1'b0;
    @(negedge clk);
    reset[0] = 1'b0;
    #1;
    check_idle_outputs(0, "after_abort");
    issue(0, 0, W, 32'h200, 32'h0, 1, 32'h1111_1111, 0);
    req_valid[0] = 1'b0;

    // ---- LATENCY=0: back-to-back with req_valid held, address aliasing ----
    issue(1, 1, W,  32'h1100, 32'hCAFE_F00D, 1, 32'h0,         0);
    issue(1, 0, W,  32'h0100, 32'h0,         1, 32'hCAFE_F00D, 0);
    issue(1, 0, BU, 32'h1103, 32'h0,         1, 32'h0000_00CA, 0);
    issue(1, 0, H,  32'h2102, 32'h0,         1, 32'hFFFF_CAFE, 0);
    issue(1, 1, H,  32'h3101, 32'h0000_BEEF, 1, 32'h0,         1);
    issue(1, 1, B,  32'h0100, 32'h1234_5677, 1, 32'h0,         0);
    issue(1, 0, W,  32'h0100, 32'h0,         1, 32'hCAFE_F077, 0);
    issue(1, 1, W,  32'h0104, 32'h5555_AAAA, 1, 32'h0,         0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b1; req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = W;
    req_addr[1] = 32'h104; req_wdata[1] = 32'hFFFF_FFFF;
    #1;
    check("i1_stall_under_reset_pulse", 32'(stall[1]), 32'd0);
    @(negedge clk);
    reset[1] = 1'b0; req_valid[1] = 1'b0;
    #1;
    check_idle_outputs(1, "after_reset_pulse");
    issue(1, 0, W, 32'h104, 32'h0, 1, 32'h5555_AAAA, 0);
    req_valid[1] = 1'b0;

    // ---- randomized traffic against the reference model ----
    for (int k = 0; k < 2; k++) begin
      init_window(k);
      rand_phase(k, 200);
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("i%0d_queue_drained", k), 32'(exp_q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Parametrised data-memory subsystem for the RISC-V pipeline; the next-generation replacement for the single-cycle, word-only data memory.
- Adds configurable wait-state latency, byte/halfword/word access with sign/zero extension, and a stall handshake to the pipeline memory stage.
- Adds misalignment and illegal-width error reporting.
- Sits between the datapath memory stage (address, write data, funct3, memwrite) and an internal byte-lane RAM.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, RAM depth in XLEN-bit words; power of two.
- LATENCY, 2, wait cycles before the access commits; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory-stage instruction is a load or store.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  access type (RV32I load/store funct3).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low bytes are used for sb/sh.
- stall  out  1  hold the pipeline stages up to and including memory.
- rsp_valid  out  1  one-cycle pulse: access complete, rsp_rdata valid.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- access_err  out  1  one-cycle pulse with rsp_valid: misaligned or illegal funct3.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- States: IDLE, WAIT, RESP. Reset forces IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, access_err=0.
- stall is combinational: (IDLE & req_valid & !reset) | WAIT. stall is 0 in RESP.
- IDLE & req_valid, legal and aligned access:
  - capture write, funct3, addr, wdata; cnt <= LATENCY.
  - go to WAIT if LATENCY > 0, else go directly to the commit step.
- WAIT: cnt decrements each cycle. When cnt==0, the access commits on that edge:
  - store: write byte lanes.
  - load: capture the extended read into rsp_rdata.
  - next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The pipeline advances at the end of RESP.
- A req_valid held high during RESP belongs to the completing instruction and is ignored. The next request is sampled in the following IDLE cycle, which gives one bubble per access.
- Latency: accept edge to rsp_valid = LATENCY+1 cycles. stall is high for LATENCY+1 cycles per access.
- Legal funct3:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - stores: 000 sb, 001 sh, 010 sw.
  - any other funct3 for the given direction is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Error path, from IDLE:
  - go to RESP next cycle with access_err=1 and rsp_rdata=0.
  - no RAM write occurs. stall is high for 1 cycle.
- Byte lanes are little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
  - sb writes wdata[7:0] to the lane; sh writes wdata[15:0]; other bytes are preserved.
- Addressing: word index = addr[$clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap.
- Reset mid-operation (WAIT): abort. A pending store is NOT committed; outputs take reset values. RAM contents are never reset.
- Loads never modify RAM. Stores return rsp_rdata=0.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum {IDLE, WAIT, RESP}.
  - function for byte-enable generation.
  - function for load extension.
- Sub-module dmem_bank:
  - DEPTH_WORDS x XLEN RAM with a per-byte write-enable vector.
  - synchronous write, asynchronous read.
  - instantiated once.

Test Plan:
1. LATENCY=2: sw 0xDEADBEEF @0x100, then lw @0x100 -> stall high 3 cycles per access; rsp_valid pulses 3 cycles after accept; rsp_rdata=0xDEADBEEF.
2. sb 0x80 @0x101, then lb @0x101 -> 0xFFFFFF80; lbu @0x101 -> 0x00000080; lw @0x100 -> 0xDEAD80EF.
3. sh 0x8001 @0x102, then lh @0x102 -> 0xFFFF8001; lhu -> 0x00008001. lw @0x102 -> access_err=1, rsp_rdata=0, stall high 1 cycle.
4. sw @0x7 or funct3=011 -> access_err pulse, RAM unchanged (read back old value); funct3=110 store -> error.
5. Reset asserted mid-WAIT of sw 0x12345678 @0x200 -> state IDLE, outputs 0 next cycle; later lw @0x200 returns the pre-store value.
6. LATENCY=0 build: back-to-back sw/lw with req_valid held -> rsp_valid 1 cycle after accept, one IDLE bubble between accesses; address 0x1000+0x100 with DEPTH_WORDS=1024 aliases 0x100.
